pmod_rx: RTL and testbench

PMOD_RX -- requirements
Module: pmod_rx

---
 rtl/pmod_rx_pkg.sv | 29 ++
 rtl/pmod_rx_hex_to_7seg.sv | 19 +
 rtl/pmod_rx.sv | 153 +++++++++++++++
 tb/tb_pmod_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pmod_rx_pkg.sv
// ============================================================================
// Module   : pmod_rx_pkg
// Brief    : Shared FSM state encoding and hex-to-7-segment table for the PMOD
//            serial link (receiver and transmitter side).
// Revision : 1.0
// ============================================================================
`default_nettype none

package pmod_rx_pkg;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE      = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_START     = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DATA      = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_STOP      = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT_IDLE = 3'd4;

    // Active-low segments, bit0 = A ... bit6 = G, indexed by hex digit.
    localparam logic [6:0] c_SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

`default_nettype wire

// File: rtl/pmod_rx_hex_to_7seg.sv
// ============================================================================
// Module   : hex_to_7seg
// Brief    : Combinational hex digit to active-low 7-segment pattern.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hex_to_7seg
    import pmod_rx_pkg::*;
(
    input  logic [3:0] i_Nibble,
    output logic [6:0] o_Segment
);

    assign o_Segment = c_SEG_TABLE[i_Nibble];

endmodule

`default_nettype wire

// File: rtl/pmod_rx.sv
// ============================================================================
// Module   : pmod_rx
// Brief    : 8N1 serial receiver with framing-error detection and registered
//            dual 7-segment hex display of the last good byte.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pmod_rx
    import pmod_rx_pkg::*;
#(
    parameter int BIT_CYCLES = 2
)
(
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       io_PMOD_1,
    output logic [7:0] o_Data,
    output logic       o_Valid,
    output logic       o_Error,
    output logic       o_Busy,
    output logic [6:0] o_Segment1,
    output logic [6:0] o_Segment2
);

    localparam int                 c_CNT_W    = $clog2(BIT_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(BIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic                 r_Sync1;
    logic                 r_Line;
    logic [c_STATE_W-1:0] r_State;
    logic [c_STATE_W-1:0] w_NextState;
    logic [c_CNT_W-1:0]   r_CycleCnt;
    logic [2:0]           r_BitIdx;
    logic [7:0]           r_Shift;
    logic [7:0]           r_Data;
    logic                 r_Valid;
    logic                 r_Error;
    logic [6:0]           r_Seg1;
    logic [6:0]           r_Seg2;
    logic [6:0]           w_SegHi;
    logic [6:0]           w_SegLo;
    logic                 w_HalfDone;
    logic                 w_BitDone;
    logic                 w_ShiftEn;
    logic                 w_LoadData;
    logic                 w_FrameErr;
    logic                 w_Busy;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Sync1 <= 1'b1;
            r_Line  <= 1'b1;
        end else begin
            r_Sync1 <= io_PMOD_1;
            r_Line  <= r_Sync1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_State <= c_ST_IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    always_comb begin
        w_NextState = r_State;
        case (r_State)
            c_ST_IDLE:      if (!r_Line) w_NextState = c_ST_START;
            c_ST_START:     if (w_HalfDone) w_NextState = r_Line ? c_ST_IDLE : c_ST_DATA;
            c_ST_DATA:      if (w_BitDone && (r_BitIdx == 3'd7)) w_NextState = c_ST_STOP;
            c_ST_STOP:      if (w_BitDone) w_NextState = r_Line ? c_ST_IDLE : c_ST_WAIT_IDLE;
            c_ST_WAIT_IDLE: if (r_Line) w_NextState = c_ST_IDLE;
            default:        w_NextState = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_HalfDone = (r_CycleCnt == c_CNT_HALF);
        w_BitDone  = (r_CycleCnt == c_CNT_FULL);
        w_Busy     = (r_State != c_ST_IDLE);
        w_ShiftEn  = (r_State == c_ST_DATA) && w_BitDone;
        w_LoadData = (r_State == c_ST_STOP) && w_BitDone && r_Line;
        w_FrameErr = (r_State == c_ST_STOP) && w_BitDone && !r_Line;
    end

    // Any state change restarts bit timing; within DATA each bit boundary does too.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_CycleCnt <= '0;
            r_BitIdx   <= 3'd0;
            r_Shift    <= 8'h00;
        end else begin
            if ((w_NextState != r_State) || w_ShiftEn) begin
                r_CycleCnt <= '0;
            end else if ((r_State != c_ST_IDLE) && (r_State != c_ST_WAIT_IDLE)) begin
                r_CycleCnt <= r_CycleCnt + c_CNT_ONE;
            end

            if (r_State == c_ST_IDLE) begin
                r_BitIdx <= 3'd0;
            end else if (w_ShiftEn) begin
                r_BitIdx <= r_BitIdx + 3'd1;
            end

            if (w_ShiftEn) begin
                r_Shift[r_BitIdx] <= r_Line;
            end
        end
    end

    hex_to_7seg u_hex_hi (
        .i_Nibble  (r_Shift[7:4]),
        .o_Segment (w_SegHi)
    );

    hex_to_7seg u_hex_lo (
        .i_Nibble  (r_Shift[3:0]),
        .o_Segment (w_SegLo)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Data  <= 8'h00;
            r_Valid <= 1'b0;
            r_Error <= 1'b0;
            r_Seg1  <= c_SEG_TABLE[0];
            r_Seg2  <= c_SEG_TABLE[0];
        end else begin
            r_Valid <= w_LoadData;
            r_Error <= w_FrameErr;
            if (w_LoadData) begin
                r_Data <= r_Shift;
                r_Seg1 <= w_SegHi;
                r_Seg2 <= w_SegLo;
            end
        end
    end

    assign o_Data     = r_Data;
    assign o_Valid    = r_Valid;
    assign o_Error    = r_Error;
    assign o_Busy     = w_Busy;
    assign o_Segment1 = r_Seg1;
    assign o_Segment2 = r_Seg2;

endmodule

`default_nettype wire

// File: tb/tb_pmod_rx.sv
// ============================================================================
// Module   : tb_pmod_rx
// Brief    : Scoreboard bench for pmod_rx (BIT_CYCLES 2 and 8 instances).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pmod_rx;

    localparam int BC  = 2;
    localparam int BC8 = 8;

    localparam logic [6:0] c_TB_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       line;
    logic       line8;
    logic [7:0] o_Data,  o_Data8;
    logic       o_Valid, o_Valid8;
    logic       o_Error, o_Error8;
    logic       o_Busy,  o_Busy8;
    logic [6:0] o_Seg1,  o_Seg1_8;
    logic [6:0] o_Seg2,  o_Seg2_8;

    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        q[$];
    exp_t        mon_e;
    logic [7:0]  last_good = 8'h00;

    pmod_rx #(.BIT_CYCLES(BC)) dut (
        .i_Clk      (clk),
        .i_Reset    (rst),
        .io_PMOD_1  (line),
        .o_Data     (o_Data),
        .o_Valid    (o_Valid),
        .o_Error    (o_Error),
        .o_Busy     (o_Busy),
        .o_Segment1 (o_Seg1),
        .o_Segment2 (o_Seg2)
    );

    pmod_rx #(.BIT_CYCLES(BC8)) dut8 (
        .i_Clk      (clk),
        .i_Reset    (rst),
        .io_PMOD_1  (line8),
        .o_Data     (o_Data8),
        .o_Valid    (o_Valid8),
        .o_Error    (o_Error8),
        .o_Busy     (o_Busy8),
        .o_Segment1 (o_Seg1_8),
        .o_Segment2 (o_Seg2_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic v, input int n);
        line = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // The expected outcome is queued when the frame starts; order is all that matters.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        exp_t e;
        e.is_err = !stop_ok;
        e.data   = d;
        q.push_back(e);
        drive(1'b0, BC);
        for (int i = 0; i < 8; i++) drive(d[i], BC);
        drive(stop_ok, BC);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            last_good = 8'h00;
        end else if (o_Valid || o_Error) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse valid=%0b error=%0b data=%02h required=no pulse",
                         o_Valid, o_Error, o_Data);
            end else begin
                mon_e = q.pop_front();
                check("pulse_exclusive", {31'd0, o_Valid & o_Error}, 32'd0);
                if (!mon_e.is_err) begin
                    check("valid_kind", {31'd0, o_Valid}, 32'd1);
                    check("data", {24'd0, o_Data}, {24'd0, mon_e.data});
                    check("seg1", {25'd0, o_Seg1}, {25'd0, c_TB_SEG[mon_e.data[7:4]]});
                    check("seg2", {25'd0, o_Seg2}, {25'd0, c_TB_SEG[mon_e.data[3:0]]});
                    last_good = mon_e.data;
                end else begin
                    check("error_kind", {31'd0, o_Error}, 32'd1);
                    check("data_held", {24'd0, o_Data}, {24'd0, last_good});
                end
            end
        end
    end

    initial begin
        logic [9:0] fb;
        logic [7:0] d;
        int         lat;
        logic [7:0] data8;

        rst   = 1'b1;
        line  = 1'b1;
        line8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data",  {24'd0, o_Data}, 32'h00);
        check("rst_valid", {31'd0, o_Valid}, 32'd0);
        check("rst_error", {31'd0, o_Error}, 32'd0);
        check("rst_busy",  {31'd0, o_Busy}, 32'd0);
        check("rst_seg1",  {25'd0, o_Seg1}, 32'h40);
        check("rst_seg2",  {25'd0, o_Seg2}, 32'h40);
        check("rst_data8", {24'd0, o_Data8}, 32'h00);
        rst = 1'b0;
        drive(1'b1, 4);

        // Single frame with idle around it.
        send_frame(8'hA5, 1'b1);
        drive(1'b1, 12);

        // One-clock glitch must be rejected.
        drive(1'b0, 1);
        drive(1'b1, 10);
        check("glitch_busy", {31'd0, o_Busy}, 32'd0);
        check("glitch_data", {24'd0, o_Data}, 32'hA5);

        // Bad stop bit, line held low, then recovery.
        send_frame(8'h3C, 1'b0);
        drive(1'b0, 6);
        check("wait_idle_busy", {31'd0, o_Busy}, 32'd1);
        check("wait_idle_data", {24'd0, o_Data}, 32'hA5);
        drive(1'b1, 2 * BC);
        send_frame(8'h11, 1'b1);
        drive(1'b1, 6);

        // Back-to-back frames with no idle bits.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h80, 1'b1);
        drive(1'b1, 12);

        // Reset during data bit 4 of 0x5A.
        d = 8'h5A;
        drive(1'b0, BC);
        for (int i = 0; i < 4; i++) drive(d[i], BC);
        drive(d[4], 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        line = 1'b1;
        check("midrst_data",  {24'd0, o_Data}, 32'h00);
        check("midrst_busy",  {31'd0, o_Busy}, 32'd0);
        check("midrst_seg1",  {25'd0, o_Seg1}, 32'h40);
        check("midrst_seg2",  {25'd0, o_Seg2}, 32'h40);
        drive(1'b1, 12);
        check("midrst_quiet", {24'd0, o_Data}, 32'h00);
        send_frame(8'h69, 1'b1);
        drive(1'b1, 8);

        // Randomized frames: random gaps (zero allowed) and occasional bad stop bits.
        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom);
            if ($urandom_range(7) == 0) begin
                send_frame(d, 1'b0);
                drive(1'b0, int'($urandom_range(4)));
                drive(1'b1, BC);
            end else begin
                send_frame(d, 1'b1);
            end
            drive(1'b1, BC * int'($urandom_range(2)));
        end
        drive(1'b1, 8);

        // Latency at BIT_CYCLES = 8, measured from the first low on the pin.
        fb    = {1'b1, 8'hC3, 1'b0};
        lat   = -1;
        data8 = 8'h00;
        for (int n = 0; n < 100 && lat < 0; n++) begin
            line8 = (n / BC8 < 10) ? fb[n / BC8] : 1'b1;
            @(posedge clk);
            #1;
            if (o_Valid8) begin
                lat   = n + 1;
                data8 = o_Data8;
                check("bc8_seg1",  {25'd0, o_Seg1_8}, {25'd0, c_TB_SEG[4'hC]});
                check("bc8_seg2",  {25'd0, o_Seg2_8}, {25'd0, c_TB_SEG[4'h3]});
                check("bc8_error", {31'd0, o_Error8}, 32'd0);
            end
        end
        check("bc8_latency", lat, 2 + BC8 * 10 - BC8 / 2 + 1);
        check("bc8_data", {24'd0, data8}, 32'hC3);
        line8 = 1'b1;
        repeat (BC8 * 2) @(posedge clk);
        #1;
        check("bc8_idle", {31'd0, o_Busy8}, 32'd0);

        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drain", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
